mem_port_arbiter: RTL and testbench

//   Shares the single-ported word-addressed data memory between two requesters:

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Desc     : Request/response bundle for one memory requester port.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32
) ();
    logic          valid;
    logic          ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          lock;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    // Plain port: no burst lock.
    modport master (
        output valid, we, addr, wdata,
        input  ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  valid, we, addr, wdata,
        output ready, resp_valid, resp_rdata, resp_err
    );

    // Lock-capable port.
    modport master_lock (
        output valid, we, addr, wdata, lock,
        input  ready, resp_valid, resp_rdata, resp_err
    );
    modport slave_lock (
        input  valid, we, addr, wdata, lock,
        output ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Desc     : Round-robin two-port arbiter in front of a single-ported word
//            memory, with registered responses and a port-1 burst lock.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int WORDS = 64,
    parameter int AW    = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mem_port_arbiter_if.slave      p0_if,
    mem_port_arbiter_if.slave_lock p1_if,
    output      logic [AW-1:0] mem_address_o,
    output      logic [31:0]   mem_write_data_o,
    output      logic          mem_write_enable_o,
    input  wire logic [31:0]   mem_read_data_i
);

    localparam logic [AW-1:0] WORDS_AW = AW'(WORDS);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e        state_q;
    logic          last_grant_q;

    logic          p0_resp_valid_q, p1_resp_valid_q;
    logic          p0_resp_err_q,   p1_resp_err_q;
    logic [31:0]   p0_resp_rdata_q, p1_resp_rdata_q;

    logic          p0_resp_err_d,   p1_resp_err_d;
    logic [31:0]   p0_resp_rdata_d, p1_resp_rdata_d;

    logic          grant0, grant1;
    logic          p0_in_range, p1_in_range;
    logic          sel_we, sel_in_range;

    // Port 1 wins when locked, when alone, or when port 0 was served last.
    always_comb begin
        p0_in_range = (p0_if.addr < WORDS_AW);
        p1_in_range = (p1_if.addr < WORDS_AW);
        grant1 = rst_n && p1_if.valid &&
                 ((state_q == ST_LOCKED) || !p0_if.valid || !last_grant_q);
        grant0 = rst_n && (state_q == ST_ARB) && p0_if.valid && !grant1;
    end

    assign p0_if.ready = grant0;
    assign p1_if.ready = grant1;

    always_comb begin
        mem_address_o    = '0;
        mem_write_data_o = '0;
        sel_we           = 1'b0;
        sel_in_range     = 1'b0;
        if (grant0) begin
            mem_address_o    = p0_if.addr;
            mem_write_data_o = p0_if.wdata;
            sel_we           = p0_if.we;
            sel_in_range     = p0_in_range;
        end else if (grant1) begin
            mem_address_o    = p1_if.addr;
            mem_write_data_o = p1_if.wdata;
            sel_we           = p1_if.we;
            sel_in_range     = p1_in_range;
        end
        mem_write_enable_o = sel_we && sel_in_range;
    end

    // Read data is captured only for in-range reads; writes and errors return 0.
    always_comb begin
        p0_resp_err_d   = grant0 && !p0_in_range;
        p1_resp_err_d   = grant1 && !p1_in_range;
        p0_resp_rdata_d = (grant0 && !p0_if.we && p0_in_range) ? mem_read_data_i : 32'h0;
        p1_resp_rdata_d = (grant1 && !p1_if.we && p1_in_range) ? mem_read_data_i : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_ARB;
            last_grant_q    <= 1'b1;
            p0_resp_valid_q <= 1'b0;
            p1_resp_valid_q <= 1'b0;
            p0_resp_err_q   <= 1'b0;
            p1_resp_err_q   <= 1'b0;
            p0_resp_rdata_q <= 32'h0;
            p1_resp_rdata_q <= 32'h0;
        end else begin
            p0_resp_valid_q <= grant0;
            p1_resp_valid_q <= grant1;
            p0_resp_err_q   <= p0_resp_err_d;
            p1_resp_err_q   <= p1_resp_err_d;
            p0_resp_rdata_q <= p0_resp_rdata_d;
            p1_resp_rdata_q <= p1_resp_rdata_d;

            if (grant0) begin
                last_grant_q <= 1'b0;
            end else if (grant1) begin
                last_grant_q <= 1'b1;
            end

            case (state_q)
                ST_ARB: begin
                    if (grant1 && p1_if.lock) begin
                        state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // An idle, unlocking port 1 also releases the memory.
                    if (!p1_if.lock && (grant1 || !p1_if.valid)) begin
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    assign p0_if.resp_valid = p0_resp_valid_q;
    assign p0_if.resp_err   = p0_resp_err_q;
    assign p0_if.resp_rdata = p0_resp_rdata_q;
    assign p1_if.resp_valid = p1_resp_valid_q;
    assign p1_if.resp_err   = p1_resp_err_q;
    assign p1_if.resp_rdata = p1_resp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Desc     : Self-checking bench for mem_port_arbiter with a memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    localparam int WORDS = 64;
    localparam int AW    = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW)) p0_if ();
    mem_port_arbiter_if #(.AW(AW)) p1_if ();

    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_write_enable;
    logic [31:0]   mem_read_data;

    mem_port_arbiter #(.WORDS(WORDS), .AW(AW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .p0_if              (p0_if),
        .p1_if              (p1_if),
        .mem_address_o      (mem_address),
        .mem_write_data_o   (mem_write_data),
        .mem_write_enable_o (mem_write_enable),
        .mem_read_data_i    (mem_read_data)
    );

    // Memory instance; out-of-range reads return junk the arbiter must mask.
    logic [31:0] mem [WORDS];
    bit          mem_inited;
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
            mem_inited <= 1'b1;
        end else if (mem_write_enable) begin
            mem[mem_address[5:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = (mem_address < WORDS) ? mem[mem_address[5:0]] : 32'hBAD0_BAD0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: decides the winner from the arbitration rules, keeps its
    // own copy of memory, and predicts the response for the next cycle.
    initial begin : model
        logic [31:0] ref_mem [WORDS];
        bit          locked;
        int          last;
        bit          started;
        bit          ev  [2];
        bit          ee  [2];
        logic [31:0] ed  [2];
        int          win;
        logic [31:0] a, wd;
        logic        w;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
        locked = 0; last = 1; started = 0;
        for (int p = 0; p < 2; p++) begin ev[p] = 0; ee[p] = 0; ed[p] = 0; end
        forever begin
            @(negedge clk);
            win = -1;
            if (started && rst_n) begin
                if (locked) begin
                    if (p1_if.valid) win = 1;
                end else if (p0_if.valid && p1_if.valid) begin
                    win = (last == 0) ? 1 : 0;
                end else if (p0_if.valid) begin
                    win = 0;
                end else if (p1_if.valid) begin
                    win = 1;
                end
            end
            a = 0; wd = 0; w = 0;
            if (win == 0) begin a = p0_if.addr; wd = p0_if.wdata; w = p0_if.we; end
            if (win == 1) begin a = p1_if.addr; wd = p1_if.wdata; w = p1_if.we; end

            if (started) begin
                chk1("p0_ready", p0_if.ready, win == 0);
                chk1("p1_ready", p1_if.ready, win == 1);
                chk("mem_address", mem_address, a);
                chk("mem_write_data", mem_write_data, wd);
                chk1("mem_write_enable", mem_write_enable, (win >= 0) && w && (a < WORDS));
                chk1("p0_resp_valid", p0_if.resp_valid, ev[0]);
                chk1("p1_resp_valid", p1_if.resp_valid, ev[1]);
                chk1("p0_resp_err", p0_if.resp_err, ee[0]);
                chk1("p1_resp_err", p1_if.resp_err, ee[1]);
                if (ev[0]) chk("p0_resp_rdata", p0_if.resp_rdata, ed[0]);
                if (ev[1]) chk("p1_resp_rdata", p1_if.resp_rdata, ed[1]);
            end

            for (int p = 0; p < 2; p++) begin ev[p] = 0; ee[p] = 0; ed[p] = 0; end
            if (!rst_n) begin
                locked  = 0;
                last    = 1;
                started = 1;
            end else if (started) begin
                if (win >= 0) begin
                    ev[win] = 1;
                    ee[win] = (a >= WORDS);
                    ed[win] = (!w && a < WORDS) ? ref_mem[a[5:0]] : 32'h0;
                    if (w && a < WORDS) ref_mem[a[5:0]] = wd;
                    last = win;
                end
                if (!locked) begin
                    locked = (win == 1) && p1_if.lock;
                end else if (!p1_if.lock && (win == 1 || !p1_if.valid)) begin
                    locked = 0;
                end
            end
        end
    end

    initial begin : stim
        bit exp0 [4];
        bit a0, a1;
        exp0 = '{1'b1, 1'b0, 1'b1, 1'b0};
        p0_if.valid = 0; p0_if.we = 0; p0_if.addr = 0; p0_if.wdata = 0; p0_if.lock = 0;
        p1_if.valid = 0; p1_if.we = 0; p1_if.addr = 0; p1_if.wdata = 0; p1_if.lock = 0;

        // Reset held two cycles with both requesters active.
        #1;
        rst_n = 0;
        p0_if.valid = 1; p0_if.addr = 9;
        p1_if.valid = 1; p1_if.addr = 9;
        cyc(); cyc();
        #2;
        chk1("rst_p0_ready", p0_if.ready, 1'b0);
        chk1("rst_p1_ready", p1_if.ready, 1'b0);
        chk1("rst_mem_we", mem_write_enable, 1'b0);
        chk1("rst_p0_resp_valid", p0_if.resp_valid, 1'b0);
        chk("rst_p0_resp_rdata", p0_if.resp_rdata, 32'h0);

        // Single port: write then read back-to-back.
        cyc();
        rst_n = 1;
        p1_if.valid = 0;
        p0_if.valid = 1; p0_if.we = 1; p0_if.addr = 5; p0_if.wdata = 32'hDEADBEEF;
        #2;
        chk1("sp_wr_ready", p0_if.ready, 1'b1);
        chk1("sp_wr_we", mem_write_enable, 1'b1);
        cyc();
        p0_if.we = 0; p0_if.wdata = 0;
        #2;
        chk1("sp_rd_ready", p0_if.ready, 1'b1);
        cyc();
        p0_if.valid = 0;
        #2;
        chk1("sp_rd_resp_valid", p0_if.resp_valid, 1'b1);
        chk("sp_rd_rdata", p0_if.resp_rdata, 32'hDEADBEEF);

        // Lock burst: port 1 writes 0..7 locked, then one unlocking write.
        cyc();
        p0_if.valid = 1; p0_if.we = 0; p0_if.addr = 3;
        p1_if.valid = 1; p1_if.we = 1; p1_if.lock = 1;
        for (int i = 0; i < 9; i++) begin
            p1_if.addr  = i;
            p1_if.wdata = 32'h100 + i;
            if (i == 8) p1_if.lock = 0;
            #2;
            chk1("lock_p0_ready", p0_if.ready, 1'b0);
            chk1("lock_p1_ready", p1_if.ready, 1'b1);
            cyc();
        end
        p1_if.valid = 0; p1_if.we = 0;
        #2;
        chk1("unlock_p0_ready", p0_if.ready, 1'b1);

        // Out-of-range write.
        cyc();
        p0_if.we = 1; p0_if.addr = 64; p0_if.wdata = 32'h12345678;
        #2;
        chk1("range_ready", p0_if.ready, 1'b1);
        chk1("range_mem_we", mem_write_enable, 1'b0);
        cyc();
        p0_if.valid = 0; p0_if.we = 0;
        #2;
        chk1("range_resp_valid", p0_if.resp_valid, 1'b1);
        chk1("range_resp_err", p0_if.resp_err, 1'b1);
        chk("range_resp_rdata", p0_if.resp_rdata, 32'h0);
        chk("range_mem0", mem[0], 32'h100);

        // Contention straight after reset: p0, p1, p0, p1.
        cyc();
        rst_n = 0;
        cyc();
        rst_n = 1;
        p0_if.valid = 1; p0_if.we = 0; p0_if.addr = 1;
        p1_if.valid = 1; p1_if.we = 0; p1_if.addr = 2; p1_if.lock = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk1("cont_p0_ready", p0_if.ready, exp0[i]);
            chk1("cont_p1_ready", p1_if.ready, !exp0[i]);
            if (i > 0) begin
                chk1("cont_p0_resp_valid", p0_if.resp_valid, exp0[i-1]);
                chk1("cont_p1_resp_valid", p1_if.resp_valid, !exp0[i-1]);
            end
            cyc();
        end

        // Reset in the middle of a locked burst.
        p0_if.valid = 0;
        p1_if.valid = 1; p1_if.we = 1; p1_if.lock = 1; p1_if.addr = 10; p1_if.wdata = 32'hA5A5A5A5;
        cyc(); cyc();
        rst_n = 0;
        p0_if.valid = 1; p0_if.we = 0; p0_if.addr = 10;
        cyc();
        rst_n = 1;
        #2;
        chk1("midlock_p0_ready", p0_if.ready, 1'b1);
        chk1("midlock_p1_ready", p1_if.ready, 1'b0);

        // Randomized traffic; requests held until accepted.
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            a0 = p0_if.valid && p0_if.ready;
            a1 = p1_if.valid && p1_if.ready;
            @(posedge clk);
            #1;
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 199) == 0) rst_n = 0;
            if (a0 || !p0_if.valid) begin
                p0_if.valid = ($urandom_range(0, 3) != 0);
                p0_if.we    = $urandom_range(0, 1) == 1;
                p0_if.addr  = $urandom_range(0, 69);
                p0_if.wdata = $urandom;
            end
            if (a1 || !p1_if.valid) begin
                p1_if.valid = ($urandom_range(0, 3) != 0);
                p1_if.we    = $urandom_range(0, 1) == 1;
                p1_if.addr  = $urandom_range(0, 69);
                p1_if.wdata = $urandom;
                p1_if.lock  = ($urandom_range(0, 2) == 0);
            end
        end

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
